// File: rtl/rifl_pkg.sv
// Shared constants for the RIFL TX path: 64b/66b sync headers, scrambler
// polynomial taps and seed, and the GT gearbox sequence range.
package rifl_pkg;

    localparam logic [1:0] SYNC_CTRL  = 2'b10;
    localparam logic [1:0] SYNC_DATA  = 2'b01;

    localparam int SCR_WIDTH  = 58;
    localparam int SCR_TAP_A  = 38;
    localparam int SCR_TAP_B  = 57;
    localparam int GB_SEQ_MAX = 32;

    localparam logic [SCR_WIDTH-1:0] SCR_INIT = 58'h3FF_FFFF_FFFF_FFFF;

endpackage

// File: rtl/tx_scrambler_gb_if.sv
// Beat interface between the TX width converter, the scrambler/gearbox
// stage and the GT external gearbox.
interface tx_scrambler_gb_if #(parameter int DWIDTH = 64);

    logic [DWIDTH-1:0] din;
    logic              sof_in;
    logic              pause_out;
    logic [DWIDTH-1:0] gt_data;
    logic [1:0]        gt_header;
    logic              gt_header_valid;
    logic [6:0]        gt_sequence;

    modport master (
        output din, sof_in,
        input  pause_out, gt_data, gt_header, gt_header_valid, gt_sequence
    );

    modport slave (
        input  din, sof_in,
        output pause_out, gt_data, gt_header, gt_header_valid, gt_sequence
    );

endinterface

// File: rtl/rifl_scrambler.sv
// Self-synchronous x^58+x^39+1 scrambler, bit-serial LSB-first per beat.
// dout is combinational; the state only advances when en is high.
module rifl_scrambler
    import rifl_pkg::*;
#(
    parameter int DWIDTH = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [DWIDTH-1:0] din,
    output logic [DWIDTH-1:0] dout
);

    logic [SCR_WIDTH-1:0] state;
    logic [SCR_WIDTH-1:0] state_nxt;

    // Unrolled serial walk: each scrambled bit is fed back before the next one.
    always_comb begin
        logic fb;
        state_nxt = state;
        dout      = '0;
        fb        = 1'b0;
        for (int i = 0; i < DWIDTH; i++) begin
            fb        = din[i] ^ state_nxt[SCR_TAP_A] ^ state_nxt[SCR_TAP_B];
            dout[i]   = fb;
            state_nxt = {state_nxt[SCR_WIDTH-2:0], fb};
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= SCR_INIT;
        else if (en)
            state <= state_nxt;
    end

endmodule

// File: rtl/tx_scrambler_gb.sv
// TX scrambler plus GT external-gearbox sequencing: sync header insertion,
// 0..32 sequence counter and the one-block pause at sequence 32.
module tx_scrambler_gb
    import rifl_pkg::*;
#(
    parameter int DWIDTH      = 64,   // 32 or 64
    parameter int SCRAMBLE_EN = 1
) (
    input  logic             clk,
    input  logic             rst,
    tx_scrambler_gb_if.slave bus
);

    // 32-bit datapath carries one 66-bit block over two cycles.
    localparam bit HALF = (DWIDTH == 32);

    logic [5:0]        seq;
    logic              ph;
    logic              pause;
    logic              consume;
    logic [DWIDTH-1:0] scr_data;

    logic [DWIDTH-1:0] data_q;
    logic [1:0]        hdr_q;
    logic              hdr_vld_q;
    logic [6:0]        seq_q;

    assign pause   = (seq == 6'(GB_SEQ_MAX));
    assign consume = !pause;

    generate
        if (SCRAMBLE_EN != 0) begin : g_scr
            rifl_scrambler #(.DWIDTH(DWIDTH)) u_scr (
                .clk  (clk),
                .rst  (rst),
                .en   (consume),
                .din  (bus.din),
                .dout (scr_data)
            );
        end else begin : g_byp
            assign scr_data = bus.din;
        end
    endgenerate

    // For 64-bit ph stays 0 and seq steps every cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            seq <= '0;
            ph  <= 1'b0;
        end else if (!HALF || ph) begin
            seq <= pause ? '0 : seq + 6'd1;
            ph  <= 1'b0;
        end else begin
            ph  <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q    <= '0;
            hdr_q     <= 2'b00;
            hdr_vld_q <= 1'b0;
            seq_q     <= '0;
        end else begin
            seq_q     <= {1'b0, seq};
            hdr_vld_q <= consume && !ph;
            if (consume) begin
                data_q <= scr_data;
                if (!ph)
                    hdr_q <= bus.sof_in ? SYNC_CTRL : SYNC_DATA;
            end
        end
    end

    assign bus.pause_out       = pause;
    assign bus.gt_data         = data_q;
    assign bus.gt_header       = hdr_q;
    assign bus.gt_header_valid = hdr_vld_q;
    assign bus.gt_sequence     = seq_q;

endmodule

// File: tb/tb_tx_scrambler_gb.sv
// Runs three tx_scrambler_gb flavours side by side (64 bypass, 64 scrambled,
// 32 scrambled) against a cycle-indexed reference model.
module tb_tx_scrambler_gb;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    tx_scrambler_gb_if #(.DWIDTH(64)) ifa ();
    tx_scrambler_gb_if #(.DWIDTH(64)) ifb ();
    tx_scrambler_gb_if #(.DWIDTH(32)) ifc ();

    tx_scrambler_gb #(.DWIDTH(64), .SCRAMBLE_EN(0)) u_a (.clk(clk), .rst(rst), .bus(ifa));
    tx_scrambler_gb #(.DWIDTH(64), .SCRAMBLE_EN(1)) u_b (.clk(clk), .rst(rst), .bus(ifb));
    tx_scrambler_gb #(.DWIDTH(32), .SCRAMBLE_EN(1)) u_c (.clk(clk), .rst(rst), .bus(ifc));

    logic [63:0] din_v [3];
    logic        sof_v [3];
    logic [63:0] o_data [3];
    logic [1:0]  o_hdr [3];
    logic        o_vld [3];
    logic        o_pause [3];
    logic [6:0]  o_seq [3];

    assign ifa.din = din_v[0];         assign ifa.sof_in = sof_v[0];
    assign ifb.din = din_v[1];         assign ifb.sof_in = sof_v[1];
    assign ifc.din = din_v[2][31:0];   assign ifc.sof_in = sof_v[2];

    assign o_data[0] = ifa.gt_data;  assign o_hdr[0] = ifa.gt_header;
    assign o_data[1] = ifb.gt_data;  assign o_hdr[1] = ifb.gt_header;
    assign o_data[2] = {32'h0, ifc.gt_data}; assign o_hdr[2] = ifc.gt_header;
    assign o_vld[0] = ifa.gt_header_valid; assign o_pause[0] = ifa.pause_out; assign o_seq[0] = ifa.gt_sequence;
    assign o_vld[1] = ifb.gt_header_valid; assign o_pause[1] = ifb.pause_out; assign o_seq[1] = ifb.gt_sequence;
    assign o_vld[2] = ifc.gt_header_valid; assign o_pause[2] = ifc.pause_out; assign o_seq[2] = ifc.gt_sequence;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s t=%0t got=%h exp=%h", tag, $time, got, exp);
        end
    endtask

    // Model state: k = clock edges since reset release; scrambled and received
    // bit streams, with bits before the stream start reading as the all-ones seed.
    int          k;
    int          seg;
    int          acnt;
    int          pcnt [3];
    bit          cons [3];
    logic [63:0] exp_data [3];
    bit          sbits [3][32768];
    bit          rbits [3][32768];
    int          sn [3];
    int          rn [3];

    function automatic int width_of(input int i);
        return (i == 2) ? 32 : 64;
    endfunction

    function automatic int seq_of(input int i, input int kk);
        return (i == 2) ? (kk / 2) % 33 : kk % 33;
    endfunction

    function automatic bit ph_of(input int i, input int kk);
        return (i == 2) && ((kk % 2) == 1);
    endfunction

    function automatic bit pz(input int i, input int kk);
        return seq_of(i, kk) == 32;
    endfunction

    function automatic bit spast(input int i, input int n);
        return (n < 0) ? 1'b1 : sbits[i][n];
    endfunction

    function automatic bit rpast(input int i, input int n);
        return (n < 0) ? 1'b1 : rbits[i][n];
    endfunction

    // out[n] = in[n] ^ out[n-39] ^ out[n-58]
    task automatic scr_model(input int i, input logic [63:0] d, output logic [63:0] o);
        o = '0;
        for (int b = 0; b < width_of(i); b++) begin
            o[b] = d[b] ^ spast(i, sn[i] - 39) ^ spast(i, sn[i] - 58);
            sbits[i][sn[i]] = o[b];
            sn[i]++;
        end
    endtask

    // in[n] = rx[n] ^ rx[n-39] ^ rx[n-58]
    task automatic dscr_model(input int i, input logic [63:0] rx, output logic [63:0] d);
        d = '0;
        for (int b = 0; b < width_of(i); b++) begin
            d[b] = rx[b] ^ rpast(i, rn[i] - 39) ^ rpast(i, rn[i] - 58);
            rbits[i][rn[i]] = rx[b];
            rn[i]++;
        end
    endtask

    task automatic new_beat(input int i);
        if (i == 0) begin
            din_v[0] = 64'(acnt);
            sof_v[0] = (acnt % 4) == 0;
            acnt++;
        end else begin
            din_v[i] = {$urandom, $urandom};
            if (i == 2) din_v[i][63:32] = '0;
            // A beat first offered during a pause always carries sof.
            sof_v[i] = pz(i, k) ? 1'b1 : ($urandom_range(3) == 0);
        end
    endtask

    task automatic do_reset(input int ncyc);
        rst = 1'b1;
        repeat (ncyc) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("rst_data%0d", i), o_data[i], 64'h0);
            chk($sformatf("rst_hdr%0d", i), 64'(o_hdr[i]), 64'h0);
            chk($sformatf("rst_vld%0d", i), 64'(o_vld[i]), 64'h0);
            chk($sformatf("rst_seq%0d", i), 64'(o_seq[i]), 64'h0);
            chk($sformatf("rst_pause%0d", i), 64'(o_pause[i]), 64'h0);
        end
        rst = 1'b0;
        k = 0;
        for (int i = 0; i < 3; i++) begin
            sn[i] = 0;
            rn[i] = 0;
            exp_data[i] = '0;
            new_beat(i);
        end
    endtask

    task automatic run_cycle();
        logic [63:0] ed [3];
        logic [1:0]  eh [3];
        bit          ev [3];
        logic [63:0] rec;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("pause%0d", i), 64'(o_pause[i]), 64'(pz(i, k)));
            if (seg == 0 && k < 99 && o_pause[i]) pcnt[i]++;
            cons[i] = !pz(i, k);
            ev[i]   = cons[i] && !ph_of(i, k);
            eh[i]   = sof_v[i] ? 2'b10 : 2'b01;
            if (cons[i]) begin
                if (i == 0) exp_data[i] = din_v[i];
                else        scr_model(i, din_v[i], exp_data[i]);
            end
            ed[i] = exp_data[i];
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("data%0d", i), o_data[i], ed[i]);
            chk($sformatf("seq%0d", i), 64'(o_seq[i]), 64'(seq_of(i, k)));
            chk($sformatf("hvld%0d", i), 64'(o_vld[i]), 64'(ev[i]));
            if (ev[i]) chk($sformatf("hdr%0d", i), 64'(o_hdr[i]), 64'(eh[i]));
            if (i != 0 && cons[i]) begin
                dscr_model(i, o_data[i], rec);
                chk($sformatf("descr%0d", i), rec, din_v[i]);
            end
        end
        k++;
        for (int i = 0; i < 3; i++)
            if (cons[i]) new_beat(i);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog t=%0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        seg  = 0;
        acnt = 0;
        for (int i = 0; i < 3; i++) begin
            din_v[i] = '0;
            sof_v[i] = 1'b0;
            pcnt[i]  = 0;
        end
        do_reset(3);
        repeat (250) run_cycle();
        chk("pcnt_a", 64'(pcnt[0]), 64'd3);
        chk("pcnt_c", 64'(pcnt[2]), 64'd2);

        // Reset lands mid-frame at seq 17 (and mid-pair on the 32-bit lane).
        for (int n = 0; n < 40 && (k % 33) != 17; n++) run_cycle();
        chk("pre_rst_seq", 64'(k % 33), 64'd17);
        seg = 1;
        do_reset(1);
        repeat (120) run_cycle();

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/tx_scrambler_gb.md
TX_SCRAMBLER_GB -- requirements
Module: tx_scrambler_gb

Interface
REQ-001 Parameter DWIDTH, default 64, GT TX data width; legal values 32 and 64 only.
REQ-002 Parameter SCRAMBLE_EN, default 1; 0 bypasses scrambling and passes data unchanged.
REQ-003 clk  input  1  sole clock; all logic is on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 din  input  DWIDTH  data beat from the TX width converter.
REQ-006 sof_in  input  1  high on the first beat of a frame.
REQ-007 pause_out  output  1  upstream holds din/sof_in this cycle; beat not consumed.
REQ-008 gt_data  output  DWIDTH  scrambled payload to GT external gearbox.
REQ-009 gt_header  output  2  64b/66b sync header.
REQ-010 gt_header_valid  output  1  gt_header is valid this cycle.
REQ-011 gt_sequence  output  7  GT gearbox sequence counter.

Function
REQ-012 Block SHALL keep sequence counter seq, range 0..32, wrapping 32 -> 0.
REQ-013 DWIDTH=64: seq SHALL advance every cycle; one 66-bit block per cycle.
REQ-014 DWIDTH=32: seq SHALL advance every second cycle via half-phase bit ph; ph=0 is the first (header-carrying) half.
REQ-015 pause_out SHALL be combinational from registers: high while seq==32 (DWIDTH=64: 1 cycle; DWIDTH=32: 2 cycles), otherwise low.
REQ-016 While pause_out high: din/sof_in ignored, scrambler state frozen, gt_data holds its previous value.
REQ-017 Consumed beats: sync header SHALL be 2'b10 when sof_in=1, else 2'b01.
REQ-018 DWIDTH=32: header SHALL be decided on the ph=0 half; the ph=1 half carries no header.
REQ-019 Scrambler: self-synchronous, polynomial x^58+x^39+1, bit-serial LSB-first within a beat; out_bit = in_bit ^ s[38] ^ s[57]; out_bit shifts into s[0].
REQ-020 Header bits SHALL NOT be scrambled and SHALL NOT enter scrambler state.
REQ-021 SCRAMBLE_EN=0: gt_data = din; headers and sequence behave identically.
REQ-022 Latency: inputs consumed at cycle N appear on gt_data/gt_header at cycle N+1; gt_sequence registered in the same cycle as its data.
REQ-023 gt_header_valid SHALL be 1 on every registered output cycle for DWIDTH=64, and only on ph=0 cycles for DWIDTH=32.
REQ-024 gt_header_valid SHALL be 0 on pause cycles.
REQ-025 gt_sequence SHALL equal the seq value with which its output cycle was generated; 7-bit zero-extended.
REQ-026 sof_in on a pause cycle SHALL be ignored and SHALL be re-sampled on the next non-pause cycle, since upstream holds it.

Reset
REQ-027 While rst=1 and on the first cycle after: seq=0, ph=0, scrambler state=58'h3FF_FFFF_FFFF_FFFF.
REQ-028 While rst=1 and on the first cycle after: gt_data=0, gt_header=2'b00, gt_header_valid=0, gt_sequence=0, pause_out=0.
REQ-029 Reset mid-pause or mid-32-bit-pair SHALL abandon the partial block; first post-reset beat is a ph=0, seq=0 beat.

Structure
REQ-030 Shared package rifl_pkg SHALL hold: SYNC_CTRL=2'b10, SYNC_DATA=2'b01, SCR_WIDTH=58, SCR_TAP_A=38, SCR_TAP_B=57, GB_SEQ_MAX=32, SCR_INIT.
REQ-031 Scrambler SHALL be sub-module rifl_scrambler (ports: clk, rst, en, din, dout), with state register and enable.
REQ-032 Sequence/pause/header logic SHALL reside in tx_scrambler_gb.

Verification
REQ-033 DWIDTH=64, SCRAMBLE_EN=0, din=incrementing 0..99, sof every 4th beat -> gt_data matches din with 1-cycle lag; seq 0..32 repeating; exactly 1 pause per 33 cycles; headers 10,01,01,01.
REQ-034 DWIDTH=64, SCRAMBLE_EN=1, 200 random beats -> gt_data equals bit-serial reference model from SCR_INIT; a descrambler model recovers din exactly.
REQ-035 DWIDTH=32 -> each gt_sequence value held 2 cycles; pause_out high exactly 2 cycles at seq=32; gt_header_valid alternates 1,0.
REQ-036 sof_in=1 presented on the seq=32 cycle and held -> consumed next cycle with gt_header=2'b10; no beat lost or duplicated.
REQ-037 rst asserted for 1 cycle at seq=17 -> all outputs 0 next cycle; sequence restarts at 0; scrambled output matches model re-seeded with SCR_INIT.
